// File: rtl/accum_bank.sv
`default_nettype none
// ============================================================================
// Module   : accum_bank
// Summary  : Row-addressed NUM_COL-wide accumulation buffer with a two-stage
//            read-modify-write pipeline, clear-on-read and a clear sweep.
//            Define ACCUM_BANK_SAT_EN for saturating arithmetic plus sat_flag.
// Revision : 1.0
// ============================================================================
module accum_bank #(
  parameter  int NUM_COL    = 16,
  parameter  int ACCUM_ROW  = 256,
  parameter  int DATA_WIDTH = 32,
  parameter  int ACC_WIDTH  = 32,
  localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_start,
  output logic                            busy,
  input  logic                            wr_en,
  input  logic                            wr_mode,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [NUM_COL*DATA_WIDTH-1:0]   wr_data,
  input  logic                            rd_en,
  input  logic                            rd_clr,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic                            rd_valid,
  output logic [NUM_COL*ACC_WIDTH-1:0]    rd_data
`ifdef ACCUM_BANK_SAT_EN
  ,
  output logic                            sat_flag
`endif
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_CLEAR = 1'b1;
  localparam int         c_ROW_W = NUM_COL * ACC_WIDTH;
  localparam int         c_IN_W  = NUM_COL * DATA_WIDTH;
`ifdef ACCUM_BANK_SAT_EN
  localparam int         c_SUM_W = ACC_WIDTH + 1;
`else
  localparam int         c_SUM_W = ACC_WIDTH;
`endif

  // Storage plus a per-row "logically zero" flag so clear-on-read needs no
  // second write port into the data array.
  logic [c_ROW_W-1:0]    mem_q [ACCUM_ROW];
  logic [ACCUM_ROW-1:0]  zero_q;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  wp_valid_q, wp_mode_q;
  logic [ADDR_WIDTH-1:0] wp_addr_q;
  logic [c_IN_W-1:0]     wp_data_q;
  logic [c_ROW_W-1:0]    wp_old_q;
  logic                  rc_valid_q;
  logic [ADDR_WIDTH-1:0] rc_addr_q;
  logic                  pc_valid_q;
  logic [ADDR_WIDTH-1:0] pc_addr_q;
  logic [c_ROW_W-1:0]    pc_data_q;
  logic                  pz_valid_q;
  logic [ADDR_WIDTH-1:0] pz_addr_q;
  logic                  rd_valid_q;
  logic [c_ROW_W-1:0]    rd_data_q;
  logic                  sat_q;

  logic                  w_busy, w_wr_acc, w_rd_acc, w_commit, w_zero;
  logic [c_ROW_W-1:0]    w_base, w_new, w_wr_row, w_rd_row, w_rd_next;
  logic [NUM_COL-1:0]    w_sat;

  assign w_busy   = (state_q == c_CLEAR);
  assign busy     = w_busy;
  assign w_wr_acc = wr_en & ~w_busy & ~clr_start;
  assign w_rd_acc = rd_en & ~w_busy & ~clr_start;
  assign w_commit = wp_valid_q & ~w_busy;
  assign w_zero   = rc_valid_q & ~w_busy;

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`ifdef ACCUM_BANK_SAT_EN
  assign sat_flag = sat_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr_start) begin
      state_d = c_CLEAR;
      cnt_d   = '0;
    end else if (state_q == c_CLEAR) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = c_IDLE;
      end
    end
  end

  assign w_wr_row = zero_q[wr_addr] ? '0 : mem_q[wr_addr];
  assign w_rd_row = zero_q[rd_addr] ? '0 : mem_q[rd_addr];

  // Old-row selection, newest effect first: same-cycle clear-on-read, then
  // last cycle's commit, then last cycle's clear, then the stage-1 read.
  always_comb begin
    if (rc_valid_q && rc_addr_q == wp_addr_q) begin
      w_base = '0;
    end else if (pc_valid_q && pc_addr_q == wp_addr_q) begin
      w_base = pc_data_q;
    end else if (pz_valid_q && pz_addr_q == wp_addr_q) begin
      w_base = '0;
    end else begin
      w_base = wp_old_q;
    end
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    logic signed [c_SUM_W-1:0] w_old_x, w_in_x, w_sum;
    assign w_old_x = c_SUM_W'($signed(w_base[c*ACC_WIDTH +: ACC_WIDTH]));
    assign w_in_x  = c_SUM_W'($signed(wp_data_q[c*DATA_WIDTH +: DATA_WIDTH]));
    assign w_sum   = wp_mode_q ? w_in_x : (w_old_x + w_in_x);
`ifdef ACCUM_BANK_SAT_EN
    assign w_sat[c] = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    assign w_new[c*ACC_WIDTH +: ACC_WIDTH] =
        !w_sat[c]        ? w_sum[ACC_WIDTH-1:0] :
        w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                           {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    assign w_sat[c] = 1'b0;
    assign w_new[c*ACC_WIDTH +: ACC_WIDTH] = w_sum;
`endif
  end

  // Read bypass: a write in stage 2 this cycle is newer than a pending clear.
  always_comb begin
    if (w_commit && wp_addr_q == rd_addr) begin
      w_rd_next = w_new;
    end else if (w_zero && rc_addr_q == rd_addr) begin
      w_rd_next = '0;
    end else begin
      w_rd_next = w_rd_row;
    end
  end

  always_ff @(posedge clk) begin
    if (w_busy) begin
      mem_q[cnt_q]  <= '0;
      zero_q[cnt_q] <= 1'b0;
    end else begin
      if (w_zero) begin
        zero_q[rc_addr_q] <= 1'b1;
      end
      if (w_commit) begin
        mem_q[wp_addr_q]  <= w_new;
        zero_q[wp_addr_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= c_CLEAR;
      cnt_q      <= '0;
      wp_valid_q <= 1'b0;
      wp_mode_q  <= 1'b0;
      wp_addr_q  <= '0;
      wp_data_q  <= '0;
      wp_old_q   <= '0;
      rc_valid_q <= 1'b0;
      rc_addr_q  <= '0;
      pc_valid_q <= 1'b0;
      pc_addr_q  <= '0;
      pc_data_q  <= '0;
      pz_valid_q <= 1'b0;
      pz_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wp_valid_q <= w_wr_acc;
      if (w_wr_acc) begin
        wp_mode_q <= wr_mode;
        wp_addr_q <= wr_addr;
        wp_data_q <= wr_data;
        wp_old_q  <= w_wr_row;
      end
      rc_valid_q <= w_rd_acc & rd_clr;
      if (w_rd_acc) begin
        rc_addr_q <= rd_addr;
      end
      pc_valid_q <= w_commit;
      if (w_commit) begin
        pc_addr_q <= wp_addr_q;
        pc_data_q <= w_new;
      end
      pz_valid_q <= w_zero;
      if (w_zero) begin
        pz_addr_q <= rc_addr_q;
      end
      rd_valid_q <= w_rd_acc;
      if (w_rd_acc) begin
        rd_data_q <= w_rd_next;
      end
      sat_q <= w_commit & (|w_sat);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accum_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_bank
// Summary  : Self-checking bench for accum_bank against a per-cycle row model.
// Revision : 1.0
// ============================================================================
module tb_accum_bank;

  localparam int NUM_COL    = 16;
  localparam int ACCUM_ROW  = 256;
  localparam int DATA_WIDTH = 32;
  localparam int ACC_WIDTH  = 32;
  localparam int ADDR_WIDTH = 8;
  localparam int ROW_W      = NUM_COL * ACC_WIDTH;
  localparam int IN_W       = NUM_COL * DATA_WIDTH;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_WIDTH - 1)) - 64'sd1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_WIDTH - 1));

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  clr_start = 1'b0;
  logic                  wr_en = 1'b0;
  logic                  wr_mode = 1'b0;
  logic [ADDR_WIDTH-1:0] wr_addr = '0;
  logic [IN_W-1:0]       wr_data = '0;
  logic                  rd_en = 1'b0;
  logic                  rd_clr = 1'b0;
  logic [ADDR_WIDTH-1:0] rd_addr = '0;
  logic                  busy;
  logic                  rd_valid;
  logic [ROW_W-1:0]      rd_data;
`ifdef ACCUM_BANK_SAT_EN
  logic                  sat_flag;
`endif

  always #5 clk = ~clk;

  accum_bank #(
    .NUM_COL(NUM_COL), .ACCUM_ROW(ACCUM_ROW),
    .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy),
    .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_clr(rd_clr), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data)
`ifdef ACCUM_BANK_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: row contents, remaining sweep cycles, expected outputs.
  logic signed [ACC_WIDTH-1:0] model [ACCUM_ROW][NUM_COL];
  int               sweep_left;
  logic             exp_valid, exp_busy, exp_sat, prev_sat;
  logic [ROW_W-1:0] exp_data;

  function automatic logic [IN_W-1:0] rand_row();
    logic [IN_W-1:0] v;
    for (int c = 0; c < NUM_COL; c++) begin
      if ($urandom_range(0, 1) == 0) v[c*DATA_WIDTH +: DATA_WIDTH] = $urandom();
      else v[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(int'($urandom_range(0, 200)) - 100);
    end
    return v;
  endfunction

  // One clock cycle: drive inputs, apply the cycle to the model (read, then
  // clear-on-read, then write), then sample 1 time unit after the edge.
  task automatic step(input logic we, input logic wm, input logic [ADDR_WIDTH-1:0] wa,
                      input logic [IN_W-1:0] wd, input logic re, input logic rc,
                      input logic [ADDR_WIDTH-1:0] ra, input logic cs);
    logic   busy_now, sat_now;
    longint s;
    logic [63:0] su;
    wr_en = we; wr_mode = wm; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_clr = rc; rd_addr = ra; clr_start = cs;
    busy_now  = (sweep_left != 0);
    sat_now   = 1'b0;
    exp_valid = 1'b0;
    if (cs) begin
      sweep_left = ACCUM_ROW;
      for (int r = 0; r < ACCUM_ROW; r++)
        for (int c = 0; c < NUM_COL; c++) model[r][c] = '0;
    end else if (busy_now) begin
      sweep_left--;
    end else begin
      if (re) begin
        exp_valid = 1'b1;
        for (int c = 0; c < NUM_COL; c++) exp_data[c*ACC_WIDTH +: ACC_WIDTH] = model[ra][c];
        if (rc) for (int c = 0; c < NUM_COL; c++) model[ra][c] = '0;
      end
      if (we) begin
        for (int c = 0; c < NUM_COL; c++) begin
          s = longint'($signed(wd[c*DATA_WIDTH +: DATA_WIDTH]));
          if (!wm) s = s + longint'(model[wa][c]);
`ifdef ACCUM_BANK_SAT_EN
          if (s > ACC_MAX) begin s = ACC_MAX; sat_now = 1'b1; end
          else if (s < ACC_MIN) begin s = ACC_MIN; sat_now = 1'b1; end
`endif
          su = s;
          model[wa][c] = su[ACC_WIDTH-1:0];
        end
      end
    end
    exp_sat  = prev_sat && !busy_now;
    prev_sat = sat_now;
    @(posedge clk);
    #1;
    exp_busy = (sweep_left != 0);
    wr_en = 1'b0; rd_en = 1'b0; rd_clr = 1'b0; clr_start = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    rst = 1'b0;
    sweep_left = ACCUM_ROW; exp_data = '0; prev_sat = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_reset: got %b expected 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < ACCUM_ROW + 20) begin idle(); n++; end
    checks++; if (n != ACCUM_ROW) begin errors++; $display("FAIL sweep_length: got %0d cycles expected %0d", n, ACCUM_ROW); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_idle: got %b expected 0", rd_valid); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL read0_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL read0_data: got %h expected 0", rd_data); end
    idle();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL read0_valid_drop: got %b expected 0", rd_valid); end
  endtask

  task automatic test_accumulate();
    logic [IN_W-1:0] wd;
    for (int i = 0; i < 4; i++) begin
      wd = rand_row();
      wd[0 +: DATA_WIDTH] = 32'd3;
      step(1'b1, 1'b0, 8'd5, wd, 1'b0, 1'b0, '0, 1'b0);
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd5, 1'b0);
    checks++; if (rd_data[0 +: ACC_WIDTH] !== 32'd12) begin errors++; $display("FAIL accum_col0: got %0d expected 12", rd_data[0 +: ACC_WIDTH]); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin errors++; $display("FAIL accum_row: got %h expected %h", rd_data, exp_data); end
  endtask

  task automatic test_overwrite_clear_on_read();
    logic [IN_W-1:0] wd;
    wd = rand_row(); wd[0 +: DATA_WIDTH] = 32'd10;
    step(1'b1, 1'b1, 8'd7, wd, 1'b0, 1'b0, '0, 1'b0);
    wd = rand_row(); wd[0 +: DATA_WIDTH] = -32'sd4;
    step(1'b1, 1'b0, 8'd7, wd, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'd7, 1'b0);
    checks++; if (rd_data[0 +: ACC_WIDTH] !== 32'd6) begin errors++; $display("FAIL ovr_col0: got %0d expected 6", rd_data[0 +: ACC_WIDTH]); end
    checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL ovr_row: got %h expected %h", rd_data, exp_data); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd7, 1'b0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== '0) begin errors++; $display("FAIL after_clr_read: got %h expected 0", rd_data); end
  endtask

  task automatic test_read_clear_same_cycle();
    logic [IN_W-1:0] wd;
    wd = rand_row(); wd[0 +: DATA_WIDTH] = 32'd5;
    step(1'b1, 1'b1, 8'd9, wd, 1'b0, 1'b0, '0, 1'b0);
    idle(); idle();
    wd = rand_row(); wd[0 +: DATA_WIDTH] = 32'd2;
    step(1'b1, 1'b0, 8'd9, wd, 1'b1, 1'b1, 8'd9, 1'b0);
    checks++; if (rd_data[0 +: ACC_WIDTH] !== 32'd5) begin errors++; $display("FAIL rc_same_col0: got %0d expected 5", rd_data[0 +: ACC_WIDTH]); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd9, 1'b0);
    checks++; if (rd_data[0 +: ACC_WIDTH] !== 32'd2) begin errors++; $display("FAIL rc_after_col0: got %0d expected 2", rd_data[0 +: ACC_WIDTH]); end
    checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL rc_after_row: got %h expected %h", rd_data, exp_data); end
  endtask

  task automatic test_overflow();
    logic [IN_W-1:0] wd;
    logic [ACC_WIDTH-1:0] want;
`ifdef ACCUM_BANK_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h8000_0000;
`endif
    wd = '0; wd[3*DATA_WIDTH +: DATA_WIDTH] = 32'h7FFF_FFFF;
    step(1'b1, 1'b1, 8'd11, wd, 1'b0, 1'b0, '0, 1'b0);
    wd = '0; wd[3*DATA_WIDTH +: DATA_WIDTH] = 32'd1;
    step(1'b1, 1'b0, 8'd11, wd, 1'b0, 1'b0, '0, 1'b0);
    idle();
`ifdef ACCUM_BANK_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b expected 1", sat_flag); end
`endif
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd11, 1'b0);
`ifdef ACCUM_BANK_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %b expected 0", sat_flag); end
`endif
    checks++; if (rd_data[3*ACC_WIDTH +: ACC_WIDTH] !== want) begin errors++; $display("FAIL overflow_col3: got %h expected %h", rd_data[3*ACC_WIDTH +: ACC_WIDTH], want); end
    checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL overflow_row: got %h expected %h", rd_data, exp_data); end
  endtask

  task automatic test_back_to_back();
    logic we, wm, re, rc;
    logic [ADDR_WIDTH-1:0] wa, ra;
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 9) < 7);
      wm = ($urandom_range(0, 9) < 2);
      re = ($urandom_range(0, 9) < 6);
      rc = ($urandom_range(0, 9) < 3);
      wa = ADDR_WIDTH'($urandom_range(0, 3));
      ra = ADDR_WIDTH'($urandom_range(0, 3));
      step(we, wm, wa, rand_row(), re, rc, ra, 1'b0);
      checks++; if (rd_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid cyc %0d: got %b expected %b", i, rd_valid, exp_valid); end
      checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL b2b_data cyc %0d: got %h expected %h", i, rd_data, exp_data); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy cyc %0d: got %b expected %b", i, busy, exp_busy); end
`ifdef ACCUM_BANK_SAT_EN
      checks++; if (sat_flag !== exp_sat) begin errors++; $display("FAIL b2b_sat cyc %0d: got %b expected %b", i, sat_flag, exp_sat); end
`endif
    end
  endtask

  task automatic test_clear_sweep();
    logic [IN_W-1:0] wd;
    int n;
    for (int i = 0; i < 6; i++) begin
      wd = rand_row();
      step(1'b1, 1'b0, ADDR_WIDTH'(i % 4), wd, 1'b1, 1'b0, 8'd1, (i == 3));
      if (i == 3) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise: got %b expected 1", busy); end
      end
    end
    wd = '0; wd[0 +: DATA_WIDTH] = 32'd8;
    step(1'b1, 1'b0, 8'd1, wd, 1'b1, 1'b0, 8'd1, 1'b0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL busy_read_ignored: got %b expected 0", rd_valid); end
    repeat (10) idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < ACCUM_ROW + 20) begin idle(); n++; end
    checks++; if (n != ACCUM_ROW) begin errors++; $display("FAIL restart_sweep_length: got %0d expected %0d", n, ACCUM_ROW); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd1, 1'b0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== '0) begin errors++; $display("FAIL row1_after_sweep: got %h expected 0", rd_data); end
    checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL row1_model: got %h expected %h", rd_data, exp_data); end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_overwrite_clear_on_read();
    test_read_clear_same_cycle();
    test_overflow();
    test_back_to_back();
    test_clear_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accum_bank.md
Name: accum_bank

Overview:
- Multi-column accumulation buffer behind the systolic array output.
- Each cycle it accepts one row of NUM_COL signed partial sums and adds them, or writes them over, into a row-addressed buffer.
- Supports a concurrent read with optional clear-on-read.
- Provides a hardware clear sweep after reset or on command.
- Two-stage read-modify-write pipeline with forwarding, so back-to-back writes to the same row are exact.

Parameters:
- NUM_COL, 16, number of accumulator columns.
- ACCUM_ROW, 256, rows per column (power of two).
- DATA_WIDTH, 32, signed input partial-sum width.
- ACC_WIDTH, 32, signed stored accumulator width (ACC_WIDTH >= DATA_WIDTH).
- ADDR_WIDTH, $clog2(ACCUM_ROW), localparam.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_start  in  1  pulse; starts a clear sweep of all rows.
- busy  out  1  high while a clear sweep is in progress.
- wr_en  in  1  write request.
- wr_mode  in  1  0 = accumulate, 1 = overwrite.
- wr_addr  in  ADDR_WIDTH  write row.
- wr_data  in  NUM_COL*DATA_WIDTH  signed values; column c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- rd_en  in  1  read request.
- rd_clr  in  1  with rd_en: zero the row after reading it.
- rd_addr  in  ADDR_WIDTH  read row.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  NUM_COL*ACC_WIDTH  row contents.

Behaviour:
- Reset (async, rst high):
  - rd_valid=0, rd_data=0, pipeline valid bits cleared.
  - FSM forced to CLEAR with sweep counter=0, so busy=1 as soon as rst deasserts.
  - The memory array itself is not reset; it is zeroed by the sweep.
- FSM states: IDLE, CLEAR.
  - CLEAR writes 0 to row cnt each cycle and increments cnt.
  - CLEAR -> IDLE after row ACCUM_ROW-1 is written; busy drops the next cycle (ACCUM_ROW cycles of busy).
  - IDLE -> CLEAR on clr_start.
  - clr_start while in CLEAR restarts the counter at 0.
- While busy:
  - wr_en, rd_en and rd_clr are ignored.
  - rd_valid stays 0.
  - Any in-flight stage-2 write is discarded.
- Write pipeline:
  - Stage 1 (accept cycle t) registers addr, mode and data, and reads the old row.
  - Stage 2 (t+1) computes new = old + sext(wr_data), or sext(wr_data) when overwriting, and commits it to memory at the end of t+1.
  - Forwarding: if the stage-2 address equals the stage-1 address, stage 2 uses the value committed in the previous cycle instead of the memory read. This makes consecutive writes to one row accumulate exactly.
- Arithmetic:
  - Per column, two's-complement, ACC_WIDTH result.
  - Default behaviour wraps modulo 2^ACC_WIDTH.
- Read:
  - rd_en at cycle t gives rd_valid=1 and rd_data at t+1.
  - Latency is 1 cycle; one read per cycle sustained.
  - Value returned = row after all writes accepted at cycles < t. This requires bypass from stage 2 and from the previous-cycle commit.
- Clear-on-read:
  - rd_en & rd_clr returns the pre-clear value; the row becomes 0 at the end of t+1.
  - A write accepted in the same cycle t to the same row accumulates onto 0, not onto the old value.
  - A write accepted at t+1 to that row sees 0.
- Simultaneous read and write to different rows: fully independent.
- Same row without rd_clr: the read does not see the same-cycle write.
- rd_data holds its last value when rd_valid=0.
- clr_start in the same cycle as wr_en/rd_en: the requests are ignored and the sweep takes priority.

Optional Feature:
- Macro: ACCUM_BANK_SAT_EN.
- When defined:
  - Accumulate and overwrite results saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] per column.
  - Adds output sat_flag (1 bit), registered. It is 1 in the cycle after a commit in which any column saturated, else 0; reset 0.
- When undefined: wrap-around arithmetic and no sat_flag port.

Test Plan:
- Reset, then idle -> busy=1 for exactly ACCUM_ROW cycles. A read of row 0 afterwards returns all columns 0 with rd_valid one cycle after rd_en.
- Write row 5 with col0=3 on 4 consecutive cycles (accumulate), then read row 5 -> col0=12; no lost updates from forwarding.
- Write row 7 = 10 (overwrite), write row 7 = -4 (accumulate), then read row 7 with rd_clr -> 6. Next read of row 7 -> 0.
- Read row 9 with rd_clr while writing row 9 += 2 in the same cycle, row previously 5 -> rd_data=5, later read=2.
- Column 3 at 0x7FFFFFFF, accumulate +1:
  - without ACCUM_BANK_SAT_EN -> 0x80000000;
  - with it -> 0x7FFFFFFF and sat_flag=1 for one cycle.
- Assert clr_start during a write stream, then write row 1 += 8 during busy -> ignored. After busy falls, read row 1 -> 0.
